// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART command arbiter.
//   arb_state_e    : sequencer state encoding
//   DEF_*_WIDTH    : default widths shared with the UART engine
//   WR_BIT         : write-flag bit position for the default command width
package uart_ctrl_pkg;

    localparam int DEF_CMD_WIDTH  = 16;
    localparam int DEF_READ_WIDTH = 8;
    localparam int WR_BIT         = DEF_CMD_WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        RESP      = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req_i      : request vector
//   last_gnt_i : index granted last; search starts at last_gnt_i+1
//   gnt_o      : winning index (0 when nothing requests)
//   any_req_o  : at least one request is present
module rr_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_gnt_i,
    output logic [IDX_W-1:0] gnt_o,
    output logic             any_req_o
);

    int   idx;
    logic found;

    // Walk the ring once starting just after the previous winner; the first
    // active request wins. Wrap is done by subtraction so non-power-of-two
    // N_REQ works.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = int'(last_gnt_i) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req_i[IDX_W'(idx)]) begin
                found = 1'b1;
                gnt_o = IDX_W'(idx);
            end
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/uart_cmd_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART command engine among N_REQ
// requesters. Issues one command at a time, waits for completion (read-data
// pulse for reads, ready low->high return for writes, or timeout) and routes
// a one-cycle response back to the originating requester.
//   clk, rst           : clock, synchronous active-high reset
//   req_vld/req_cmd    : per-requester command valid / packed commands
//   req_rdy            : one-hot accept pulse
//   rsp_vld/rsp_data/rsp_err : one-hot response pulse, read data, timeout flag
//   cmd_in/cmd_vld/cmd_rdy   : engine command handshake
//   read_rdy/read_data : engine read-data pulse and data
//   busy               : sequencer not idle
module uart_cmd_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int CMD_WIDTH  = DEF_CMD_WIDTH,
    parameter int READ_WIDTH = DEF_READ_WIDTH,
    parameter int TIMEOUT    = 65535
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_vld,
    input  logic [N_REQ*CMD_WIDTH-1:0] req_cmd,
    output logic [N_REQ-1:0]           req_rdy,
    output logic [N_REQ-1:0]           rsp_vld,
    output logic [READ_WIDTH-1:0]      rsp_data,
    output logic                       rsp_err,
    output logic [CMD_WIDTH-1:0]       cmd_in,
    output logic                       cmd_vld,
    input  logic                       cmd_rdy,
    input  logic                       read_rdy,
    input  logic [READ_WIDTH-1:0]      read_data,
    output logic                       busy
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e                         state_q, state_d;
    logic [IDX_W-1:0]                   gnt_q, gnt_d;
    logic [IDX_W-1:0]                   last_gnt_q, last_gnt_d;
    logic [CMD_WIDTH-1:0]               cmd_buf_q, cmd_buf_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic                               seen_low_q, seen_low_d;
    logic                               cmd_vld_q, cmd_vld_d;
    logic [N_REQ-1:0]                   req_rdy_q, req_rdy_d;
    logic [N_REQ-1:0]                   rsp_vld_q, rsp_vld_d;
    logic [READ_WIDTH-1:0]              rsp_data_q, rsp_data_d;
    logic                               rsp_err_q, rsp_err_d;
    logic                               busy_q, busy_d;

    logic [N_REQ-1:0][CMD_WIDTH-1:0]    cmd_arr;
    logic [IDX_W-1:0]                   arb_gnt;
    logic                               any_req;
    logic                               is_wr;
    logic                               rd_done, wr_done;

    assign cmd_arr = req_cmd;
    assign is_wr   = cmd_buf_q[CMD_WIDTH-1];

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i      (req_vld),
        .last_gnt_i (last_gnt_q),
        .gnt_o      (arb_gnt),
        .any_req_o  (any_req)
    );

    // Write completion needs the engine to have dropped ready at least once
    // after the handshake, otherwise the ready we see is still the pre-accept one.
    assign rd_done = !is_wr && read_rdy;
    assign wr_done =  is_wr && cmd_rdy && seen_low_q;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        cmd_buf_d  = cmd_buf_q;
        cnt_d      = cnt_q;
        seen_low_d = seen_low_q;
        cmd_vld_d  = 1'b0;
        req_rdy_d  = '0;
        rsp_vld_d  = '0;
        rsp_data_d = '0;
        rsp_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    cmd_buf_d          = cmd_arr[arb_gnt];
                    gnt_d              = arb_gnt;
                    cmd_vld_d          = 1'b1;
                    req_rdy_d[arb_gnt] = 1'b1;
                    state_d            = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_rdy) begin
                    cnt_d      = '0;
                    seen_low_d = 1'b0;
                    state_d    = WAIT_DONE;
                end else begin
                    cmd_vld_d  = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                if (is_wr && !cmd_rdy) seen_low_d = 1'b1;
                // Completion is checked before the timeout so a same-cycle
                // read pulse still returns good data.
                if (rd_done) begin
                    rsp_data_d       = read_data;
                    rsp_vld_d[gnt_q] = 1'b1;
                    state_d          = RESP;
                end else if (wr_done) begin
                    rsp_vld_d[gnt_q] = 1'b1;
                    state_d          = RESP;
                end else if (cnt_q >= CNT_LAST) begin
                    rsp_err_d        = 1'b1;
                    rsp_vld_d[gnt_q] = 1'b1;
                    state_d          = RESP;
                end
            end
            RESP: begin
                last_gnt_d = gnt_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            last_gnt_q <= IDX_W'(N_REQ - 1);
            cmd_buf_q  <= '0;
            cnt_q      <= '0;
            seen_low_q <= 1'b0;
            cmd_vld_q  <= 1'b0;
            req_rdy_q  <= '0;
            rsp_vld_q  <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            cmd_buf_q  <= cmd_buf_d;
            cnt_q      <= cnt_d;
            seen_low_q <= seen_low_d;
            cmd_vld_q  <= cmd_vld_d;
            req_rdy_q  <= req_rdy_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            busy_q     <= busy_d;
        end
    end

    assign req_rdy  = req_rdy_q;
    assign rsp_vld  = rsp_vld_q;
    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;
    assign cmd_in   = cmd_buf_q;
    assign cmd_vld  = cmd_vld_q;
    assign busy     = busy_q;

endmodule
